// File: rtl/console_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// console_rx_fifo_pkg
// Shared constants and types for the console receive FIFO:
//   UART_NO_DATA  - value the UART data register reads as when it holds no byte
//   DEFAULT_DEPTH - default number of byte entries in the FIFO
//   rx_state_t    - encoding of the UART poll FSM (also exported for debug)
// -----------------------------------------------------------------------------
package console_rx_fifo_pkg;

  localparam int          DEFAULT_DEPTH = 16;
  localparam logic [31:0] UART_NO_DATA  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_POLL   = 2'd0,
    ST_ACK    = 2'd1,
    ST_SETTLE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/console_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// console_rx_fifo_mem
// Byte-wide simple dual-port storage: one write port and one synchronous read
// port, written so that it maps onto iCE40 block RAM (no reset, registered
// read data).
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data (8 bits)
//   i_raddr  - read address, sampled on the rising edge
//   o_rdata  - read data, valid the cycle after i_raddr is sampled
// -----------------------------------------------------------------------------
module console_rx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/console_rx_fifo.sv
// -----------------------------------------------------------------------------
// console_rx_fifo
// Polls the console UART data register, moves received bytes into a FIFO and
// presents the head byte to the CPU in show-ahead form.
//
// Optional feature: define CONSOLE_RX_OVF_EN to drain and drop bytes that
// arrive while the FIFO is full (setting sticky ovf). Without it the FIFO
// applies backpressure: the byte stays in the UART until space frees up.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - synchronous active-high reset
//   uart_dat_do  - UART data register; UART_NO_DATA when no byte is held
//   uart_dat_re  - one-cycle pulse consuming the byte held in the UART
//   cpu_rd       - single-cycle pop request
//   cpu_rdata    - head byte zero-extended, 0 when empty
//   cpu_empty    - FIFO holds no bytes
//   cpu_count    - number of bytes held
//   ovf          - sticky overflow flag (always 0 without CONSOLE_RX_OVF_EN)
//   ovf_clr      - clears ovf
//   dbg_state    - current poll FSM state (rx_state_t encoding)
//
// Handshake: the UART side is a poll/acknowledge protocol. A byte is taken
// when uart_dat_do != UART_NO_DATA in ST_POLL; uart_dat_re is high for exactly
// the one ST_ACK cycle that follows, and ST_SETTLE then ignores uart_dat_do
// for one cycle while the UART register updates. The CPU side is a pop-only
// interface: cpu_rdata is always the head, and a cpu_rd seen at a rising edge
// with cpu_empty=0 removes it (cpu_rd while empty has no effect).
// -----------------------------------------------------------------------------
module console_rx_fifo
  import console_rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              uart_dat_do,
  output logic                     uart_dat_re,
  input  logic                     cpu_rd,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_empty,
  output logic [$clog2(DEPTH):0]   cpu_count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rx_state_t     r_state;
  rx_state_t     w_next_state;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_byp_sel;
  logic [7:0]    r_byp_data;
  logic          r_ovf;

  logic          w_byte_avail;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf_set;
  logic          w_bypass;
  logic [AW-1:0] w_head_next;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_mem_rdata;

  assign w_byte_avail = (uart_dat_do != UART_NO_DATA);
  // Full uses the count at the start of the cycle, so a pop in the same cycle
  // never makes room for a write.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = cpu_rd && !w_empty;

  // Poll FSM: next state and write/overflow strobes.
  always_comb begin
    w_next_state = r_state;
    w_wr         = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      ST_POLL: begin
        if (w_byte_avail) begin
          if (!w_full) begin
            w_wr         = 1'b1;
            w_next_state = ST_ACK;
          end
`ifdef CONSOLE_RX_OVF_EN
          else begin
            // Drain the byte from the UART and drop it.
            w_ovf_set    = 1'b1;
            w_next_state = ST_ACK;
          end
`endif
        end
      end
      ST_ACK:    w_next_state = ST_SETTLE;
      ST_SETTLE: w_next_state = ST_POLL;
      default:   w_next_state = ST_POLL;
    endcase
  end

  assign w_head_next = w_pop ? (r_head + AW'(1)) : r_head;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // The RAM read of the new head returns stale data when the new head is the
  // very entry being written this edge (FIFO empty after any pop). In that
  // case the written byte is captured in a bypass register instead.
  assign w_bypass = w_wr && (r_count == (w_pop ? CW'(1) : CW'(0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_POLL;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_byp_sel  <= 1'b0;
      r_byp_data <= 8'h00;
      r_ovf      <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_head    <= w_head_next;
      r_count   <= w_count_next;
      r_byp_sel <= w_bypass;
      if (w_wr) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_bypass) begin
        r_byp_data <= uart_dat_do[7:0];
      end
      // A set event wins over a clear in the same cycle.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  console_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_tail),
    .i_wdata (uart_dat_do[7:0]),
    .i_raddr (w_head_next),
    .o_rdata (w_mem_rdata)
  );

  assign uart_dat_re = (r_state == ST_ACK);
  assign cpu_empty   = w_empty;
  assign cpu_count   = r_count;
  assign cpu_rdata   = w_empty   ? 32'h0 :
                       r_byp_sel ? {24'h0, r_byp_data} :
                                   {24'h0, w_mem_rdata};
  assign ovf         = r_ovf;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_console_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_console_rx_fifo
// Self-checking bench for console_rx_fifo (DEPTH=16). A behavioural UART model
// holds a queue of bytes, presents the head on uart_dat_do and drops it when
// uart_dat_re is seen. Every byte sent is pushed to exp_q and checked against
// cpu_rdata when the bench pops it.
// -----------------------------------------------------------------------------
module tb_console_rx_fifo;
  import console_rx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   uart_dat_do = 32'hFFFF_FFFF;
  logic          uart_dat_re;
  logic          cpu_rd = 1'b0;
  logic [31:0]   cpu_rdata;
  logic          cpu_empty;
  logic [CW-1:0] cpu_count;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  console_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_dat_do (uart_dat_do),
    .uart_dat_re (uart_dat_re),
    .cpu_rd      (cpu_rd),
    .cpu_rdata   (cpu_rdata),
    .cpu_empty   (cpu_empty),
    .cpu_count   (cpu_count),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .dbg_state   (dbg_state)
  );

  // ---------------- UART model ----------------
  logic [7:0] uq[$];
  int         re_cnt = 0;

  always @(negedge clk) begin
    if (uart_dat_re) begin
      re_cnt++;
      if (uq.size() > 0) void'(uq.pop_front());
    end
    uart_dat_do = (uq.size() > 0) ? {24'h0, uq[0]} : 32'hFFFF_FFFF;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_kept);
    uq.push_back(b);
    if (expect_kept) exp_q.push_back(b);
  endtask

  // Check head against the scoreboard, then pop it on the next edge.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, cpu_rdata, {24'h0, e});
    end
    cpu_rd = 1'b1;
    tick(1);
    cpu_rd = 1'b0;
  endtask

  task automatic wait_re(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (uart_dat_re) seen = 1'b1;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit         seen;
    int         re0;
    logic [7:0] b;

    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_empty", {31'b0, cpu_empty}, 32'd1);
    check("rst_count", {27'b0, cpu_count}, 32'd0);
    check("rst_re",    {31'b0, uart_dat_re}, 32'd0);
    check("rst_ovf",   {31'b0, ovf}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_POLL});

    // Single byte: one acknowledge, visible the cycle after the write edge
    re0 = re_cnt;
    send_byte(8'h41, 1'b1);
    wait_re(seen);
    check("a_re_seen", {31'b0, seen}, 32'd1);
    check("a_latency_rdata", cpu_rdata, 32'h41);
    check("a_latency_empty", {31'b0, cpu_empty}, 32'd0);
    tick(4);
    check("a_re_pulses", re_cnt - re0, 32'd1);
    check("a_count", {27'b0, cpu_count}, 32'd1);
    check("a_rdata_hold", cpu_rdata, 32'h41);
    pop_check("a_pop");
    check("a_empty_after", {31'b0, cpu_empty}, 32'd1);
    check("a_rdata_after", cpu_rdata, 32'h0);

    // Three bytes then three back-to-back pops
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    send_byte(8'h33, 1'b1);
    tick(12);
    check("b_count", {27'b0, cpu_count}, 32'd3);
    for (int i = 0; i < 3; i++) pop_check("b_pop");
    check("b_rdata_zero", cpu_rdata, 32'h0);
    check("b_empty", {31'b0, cpu_empty}, 32'd1);

    // Pop on empty FIFO is ignored
    cpu_rd = 1'b1;
    tick(1);
    cpu_rd = 1'b0;
    check("c_count", {27'b0, cpu_count}, 32'd0);
    check("c_rdata", cpu_rdata, 32'h0);
    tick(1);
    check("c_empty", {31'b0, cpu_empty}, 32'd1);

    // Simultaneous write and pop at count 5
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b1);
    tick(18);
    check("d_count5", {27'b0, cpu_count}, 32'd5);
    send_byte(8'h60, 1'b1);        // sampled at the same edge as the pop
    pop_check("d_pop_wr");
    check("d_state_ack", {30'b0, dbg_state}, {30'b0, ST_ACK});
    check("d_count_same", {27'b0, cpu_count}, 32'd5);
    tick(3);
    while (exp_q.size() > 0) pop_check("d_order");
    check("d_empty", {31'b0, cpu_empty}, 32'd1);

    // Fill past DEPTH (pointers wrap during this phase)
    re0 = re_cnt;
`ifdef CONSOLE_RX_OVF_EN
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h80 + 8'(i), i < DEPTH);
    tick(60);
    check("e_count_full", {27'b0, cpu_count}, 32'd16);
    check("e_ovf", {31'b0, ovf}, 32'd1);
    check("e_uart_drained", uq.size(), 32'd0);
    check("e_re_pulses", re_cnt - re0, 32'd17);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("e_ovf_clr", {31'b0, ovf}, 32'd0);
`else
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h80 + 8'(i), 1'b1);
    tick(60);
    check("e_count_full", {27'b0, cpu_count}, 32'd16);
    check("e_ovf", {31'b0, ovf}, 32'd0);
    check("e_uart_held", uq.size(), 32'd1);
    check("e_re_pulses", re_cnt - re0, 32'd16);
    pop_check("e_pop_full");
    // Pop in the same cycle as full does not let the write in
    check("e_state_poll", {30'b0, dbg_state}, {30'b0, ST_POLL});
    check("e_count15", {27'b0, cpu_count}, 32'd15);
    tick(6);
    check("e_count_refill", {27'b0, cpu_count}, 32'd16);
    check("e_re_pulses2", re_cnt - re0, 32'd17);
    check("e_uart_empty", uq.size(), 32'd0);
`endif
    while (exp_q.size() > 0) pop_check("e_order");
    check("e_empty", {31'b0, cpu_empty}, 32'd1);

    // Reset during ACK aborts and discards
    send_byte(8'h77, 1'b1);
    wait_re(seen);
    check("f_re_seen", {31'b0, seen}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(exp_q.pop_front());
    check("f_re", {31'b0, uart_dat_re}, 32'd0);
    check("f_count", {27'b0, cpu_count}, 32'd0);
    check("f_state", {30'b0, dbg_state}, {30'b0, ST_POLL});
    check("f_rdata", cpu_rdata, 32'h0);

    // Random traffic with scoreboard pops
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0 && uq.size() < 3) begin
        b = 8'($urandom_range(0, 255));
        send_byte(b, 1'b1);
      end
      if ($urandom_range(0, 1) == 1 && !cpu_empty && exp_q.size() > 0) begin
        pop_check("r_pop");
      end else begin
        tick(1);
      end
    end
    tick(15);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) pop_check("r_drain");
    check("r_sb_empty", exp_q.size(), 32'd0);
    check("r_empty", {31'b0, cpu_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
